// File: rtl/ramen_pkg.sv
// Shared constants for the ramen shop controller: ingredient indices,
// opening stock, recipe table, menu prices and the FSM state type.
`default_nettype none

package ramen_pkg;

    localparam int N_ING   = 5;
    localparam int STOCK_W = 16;

    localparam int NOODLE        = 0;
    localparam int BROTH         = 1;
    localparam int TONKOTSU_SOUP = 2;
    localparam int MISO          = 3;
    localparam int SOY           = 4;

    // RECIPE[id][portion][ingredient], ingredient order NOODLE..SOY
    localparam int RECIPE [8][2][N_ING] = '{
        '{'{100, 300, 150,  0,  0}, '{150, 500, 200,  0,  0}},
        '{'{100, 300, 100,  0, 30}, '{150, 500, 150,  0, 50}},
        '{'{100, 400,   0, 30,  0}, '{150, 650,   0, 50,  0}},
        '{'{100, 300,  70, 15, 15}, '{150, 500, 100, 25, 25}},
        '{'{100, 350,   0,  0,  0}, '{150, 550,   0,  0,  0}},
        '{'{100, 300,   0,  0, 40}, '{150, 500,   0,  0, 60}},
        '{'{100, 400,   0, 40,  0}, '{150, 650,   0, 60,  0}},
        '{'{200, 200, 100,  0,  0}, '{300, 300, 150,  0,  0}}
    };

    localparam int PRICE [8] = '{200, 250, 200, 250, 180, 200, 280, 300};

    typedef logic [N_ING-1:0][STOCK_W-1:0] stock_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELL   = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    function automatic stock_vec_t init_stock();
        stock_vec_t v;
        v                = '0;
        v[NOODLE]        = 16'd12000;
        v[BROTH]         = 16'd41000;
        v[TONKOTSU_SOUP] = 16'd9000;
        v[MISO]          = 16'd1000;
        v[SOY]           = 16'd1500;
        return v;
    endfunction

    function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                   input logic [STOCK_W-1:0] b);
        logic [STOCK_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STOCK_W] ? {STOCK_W{1'b1}} : s[STOCK_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ramen_recipe_chk.sv
// Combinational recipe check: decides whether an order can be filled from
// the current stock and returns the per-ingredient deduction (zero on failure).
`default_nettype none

module ramen_recipe_chk
    import ramen_pkg::*;
#(
    parameter int N_TYPES = 4,
    parameter int TYPE_W  = 3
) (
    input  logic [TYPE_W-1:0] ramen_type_i,
    input  logic              portion_i,
    input  stock_vec_t        stock_i,
    output logic              success_o,
    output stock_vec_t        deduct_o
);

    logic [2:0] idx;
    logic       legal;
    logic       enough;
    stock_vec_t need;

    always_comb begin
        idx    = 3'(ramen_type_i);
        legal  = (int'(ramen_type_i) < N_TYPES) && (int'(ramen_type_i) < 8);
        enough = 1'b1;
        need   = '0;
        for (int k = 0; k < N_ING; k++) begin
            need[k] = 16'(RECIPE[idx][portion_i][k]);
            if (stock_i[k] < need[k]) begin
                enough = 1'b0;
            end
        end
        success_o = legal && enough;
        deduct_o  = success_o ? need : '0;
    end

endmodule

`default_nettype wire

// File: rtl/ramen_shop_ctrl.sv
// Pipelined ramen sales controller: per-order success after two cycles and a
// per-session sold/gain report. Optional restock port enabled by RAMEN_RESTOCK_EN.
`default_nettype none

module ramen_shop_ctrl
    import ramen_pkg::*;
#(
    parameter int N_TYPES = 4,
    parameter int TYPE_W  = 3,
    parameter int CNT_W   = 7,
    parameter int GAIN_W  = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     selling,
    input  logic [TYPE_W-1:0]        ramen_type,
    input  logic                     portion,
    output logic                     out_valid_order,
    output logic                     success,
    output logic                     out_valid_tot,
    output logic [N_TYPES*CNT_W-1:0] sold_num,
    output logic [GAIN_W-1:0]        total_gain
`ifdef RAMEN_RESTOCK_EN
    ,
    input  logic                     restock_valid,
    input  logic [2:0]               restock_id,
    input  logic [15:0]              restock_amt,
    output logic                     restock_ready
`endif
);

    state_e              state_q, state_d;
    logic                s1_valid_q;
    logic [TYPE_W-1:0]   s1_type_q;
    logic                s1_portion_q;
    logic                ov_q;
    logic                succ_q;
    stock_vec_t          stock_q;
    logic [CNT_W-1:0]    cnt_q [N_TYPES];

    logic                pipe_empty;
    logic                accept;
    logic                load_init;
    logic                clear_cnt;
    logic                restock_block;
    logic                chk_success;
    logic                commit;
    stock_vec_t          chk_deduct;

    assign pipe_empty = !s1_valid_q && !ov_q;
    assign commit     = s1_valid_q && chk_success;

`ifdef RAMEN_RESTOCK_EN
    logic restock_fire;
    assign restock_ready = (state_q == ST_SELL) && pipe_empty;
    assign restock_fire  = restock_valid && restock_ready;
    assign restock_block = restock_valid;
`else
    assign restock_block = 1'b0;
`endif

    ramen_recipe_chk #(
        .N_TYPES (N_TYPES),
        .TYPE_W  (TYPE_W)
    ) u_chk (
        .ramen_type_i (s1_type_q),
        .portion_i    (s1_portion_q),
        .stock_i      (stock_q),
        .success_o    (chk_success),
        .deduct_o     (chk_deduct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The S2 result register does not hold the session open: its commit is
    // already done, so REPORT may follow directly behind it.
    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        out_valid_tot = 1'b0;
        accept        = 1'b0;
        load_init     = 1'b0;
        clear_cnt     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && selling) begin
                    accept    = 1'b1;
                    load_init = 1'b1;
                    state_d   = ST_SELL;
                end
            end
            ST_SELL: begin
                in_ready = pipe_empty && !restock_block;
                accept   = in_valid && in_ready;
                if (!selling && !s1_valid_q && !accept) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                out_valid_tot = 1'b1;
                clear_cnt     = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_type_q    <= '0;
            s1_portion_q <= 1'b0;
            ov_q         <= 1'b0;
            succ_q       <= 1'b0;
            stock_q      <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_type_q    <= ramen_type;
                s1_portion_q <= portion;
            end
            ov_q   <= s1_valid_q;
            succ_q <= commit;

            if (load_init) begin
                stock_q <= init_stock();
            end else if (commit) begin
                for (int k = 0; k < N_ING; k++) begin
                    stock_q[k] <= stock_q[k] - chk_deduct[k];
                end
            end
`ifdef RAMEN_RESTOCK_EN
            else if (restock_fire) begin
                for (int k = 0; k < N_ING; k++) begin
                    if (restock_id == 3'(k)) begin
                        stock_q[k] <= sat_add(stock_q[k], restock_amt);
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TYPES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_TYPES; i++) begin
                if (clear_cnt) begin
                    cnt_q[i] <= '0;
                end else if (commit && (s1_type_q == TYPE_W'(i)) && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid_order = ov_q;
    assign success         = succ_q;

    // Gain accumulates modulo 2^GAIN_W, which is the required truncation.
    always_comb begin
        logic [CNT_W+8:0] prod;
        logic [GAIN_W-1:0] acc;
        sold_num   = '0;
        total_gain = '0;
        acc        = '0;
        prod       = '0;
        for (int i = 0; i < N_TYPES; i++) begin
            prod = (CNT_W+9)'(cnt_q[i]) * (CNT_W+9)'(PRICE[i]);
            acc  = acc + GAIN_W'(prod);
        end
        if (state_q == ST_REPORT) begin
            for (int i = 0; i < N_TYPES; i++) begin
                sold_num[(N_TYPES-1-i)*CNT_W +: CNT_W] = cnt_q[i];
            end
            total_gain = acc;
        end
    end

endmodule

`default_nettype wire
